// File: rtl/reg_file_scb.sv
// Register file with a per-entry pending scoreboard and a sequential clear sweep.
// Combinational reads with optional same-cycle write forwarding.
module reg_file_scb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_wren_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  input  logic              clr_req_i,
  output logic              clr_busy_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [Depth-1:0]  pend_q, pend_d;

  logic is_idle, wr_commit, iss_set;
  logic zero1, zero2, fwd1, fwd2;

  // Gating with rst_i keeps forwarding from leaking write data while reset is held.
  assign is_idle   = (state_q == StIdle) && !rst_i;
  assign wr_commit = is_idle && rd_wren_i && !((ZERO_REG != 0) && (rd_addr_i == '0));
  assign iss_set   = is_idle && iss_valid_i && !((ZERO_REG != 0) && (iss_addr_i == '0));

  assign zero1 = (ZERO_REG != 0) && (rs1_addr_i == '0);
  assign zero2 = (ZERO_REG != 0) && (rs2_addr_i == '0);
  assign fwd1  = (BYPASS != 0) && wr_commit && (rd_addr_i == rs1_addr_i);
  assign fwd2  = (BYPASS != 0) && wr_commit && (rd_addr_i == rs2_addr_i);

  always_comb begin
    rs1_data_o = mem_q[rs1_addr_i];
    rs2_data_o = mem_q[rs2_addr_i];
    if (fwd1) rs1_data_o = rd_data_i;
    if (fwd2) rs2_data_o = rd_data_i;
    if (zero1) rs1_data_o = '0;
    if (zero2) rs2_data_o = '0;
    rs1_busy_o = is_idle && !zero1 && pend_q[rs1_addr_i] && !fwd1;
    rs2_busy_o = is_idle && !zero2 && pend_q[rs2_addr_i] && !fwd2;
    clr_busy_o = (state_q == StClear);
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_d     = mem_q;
    pend_d    = pend_q;
    unique case (state_q)
      StIdle: begin
        if (wr_commit) begin
          mem_d[rd_addr_i]  = rd_data_i;
          pend_d[rd_addr_i] = 1'b0;
        end
        // Set after clear: a new producer issued on the commit edge keeps the bit.
        if (iss_set) pend_d[iss_addr_i] = 1'b1;
        if (clr_req_i) begin
          state_d   = StClear;
          clr_idx_d = '0;
          pend_d    = '0;
        end
      end
      StClear: begin
        mem_d[clr_idx_q] = '0;
        clr_idx_d        = clr_idx_q + ADDR_W'(1);
        if (&clr_idx_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
      mem_q     <= '{default: '0};
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      mem_q     <= mem_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_reg_file_scb.sv
// Directed self-checking bench for reg_file_scb; a second instance with BYPASS=0
// shares all inputs so forwarding and non-forwarding behaviour are compared side by side.
module tb_reg_file_scb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rd_wren_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, iss_addr_i;
  logic        iss_valid_i, clr_req_i;

  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic        rs1_busy, rs2_busy, clr_busy, nb_rs1_busy, nb_rs2_busy, nb_clr_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  reg_file_scb u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_wren_i  (rd_wren_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .iss_valid_i(iss_valid_i),
    .iss_addr_i (iss_addr_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .clr_req_i  (clr_req_i),
    .clr_busy_o (clr_busy)
  );

  reg_file_scb #(.BYPASS(0)) u_dut_nb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_wren_i  (rd_wren_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (nb_rs1_data),
    .rs2_data_o (nb_rs2_data),
    .iss_valid_i(iss_valid_i),
    .iss_addr_i (iss_addr_i),
    .rs1_busy_o (nb_rs1_busy),
    .rs2_busy_o (nb_rs2_busy),
    .clr_req_i  (clr_req_i),
    .clr_busy_o (nb_clr_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the next negedge and return all control inputs to quiet.
  task automatic step();
    @(negedge clk_i);
    rd_wren_i   = 1'b0;
    iss_valid_i = 1'b0;
    clr_req_i   = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    rd_wren_i   = 1'b0;
    rd_addr_i   = '0;
    rd_data_i   = '0;
    rs1_addr_i  = 5'd5;
    rs2_addr_i  = 5'd7;
    iss_valid_i = 1'b0;
    iss_addr_i  = '0;
    clr_req_i   = 1'b0;
    #3;
    check_eq("rst_rs1_data", rs1_data, 32'h0);
    check_eq("rst_rs1_busy", {31'b0, rs1_busy}, 32'h0);
    check_eq("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Write 5 with forwarding vs. without
    step();
    rd_wren_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'hDEADBEEF; rs1_addr_i = 5'd5;
    #1;
    check_eq("wr5_bypass", rs1_data, 32'hDEADBEEF);
    check_eq("wr5_nobypass", nb_rs1_data, 32'h0);
    step();
    #1;
    check_eq("rd5_after", rs1_data, 32'hDEADBEEF);
    check_eq("rd5_after_nb", nb_rs1_data, 32'hDEADBEEF);

    // Entry 0 hardwired
    step();
    rd_wren_i = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'h1234; rs2_addr_i = 5'd0;
    #1;
    check_eq("wr0_same_cycle", rs2_data, 32'h0);
    step();
    iss_valid_i = 1'b1; iss_addr_i = 5'd0;
    #1;
    check_eq("rd0_after", rs2_data, 32'h0);
    step();
    #1;
    check_eq("iss0_busy", {31'b0, rs2_busy}, 32'h0);

    // Scoreboard on entry 7
    step();
    iss_valid_i = 1'b1; iss_addr_i = 5'd7; rs1_addr_i = 5'd7;
    #1;
    check_eq("iss7_before_edge", {31'b0, rs1_busy}, 32'h0);
    step();
    #1;
    check_eq("iss7_busy", {31'b0, rs1_busy}, 32'h1);
    check_eq("iss7_busy_nb", {31'b0, nb_rs1_busy}, 32'h1);
    step();
    rd_wren_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h77;
    #1;
    check_eq("wr7_busy_bypass", {31'b0, rs1_busy}, 32'h0);
    check_eq("wr7_busy_nb", {31'b0, nb_rs1_busy}, 32'h1);
    check_eq("wr7_data_bypass", rs1_data, 32'h77);
    step();
    #1;
    check_eq("wr7_busy_after", {31'b0, rs1_busy}, 32'h0);
    check_eq("wr7_busy_after_nb", {31'b0, nb_rs1_busy}, 32'h0);
    step();
    rd_wren_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h88;
    iss_valid_i = 1'b1; iss_addr_i = 5'd7;
    step();
    #1;
    check_eq("iss_wr7_busy", {31'b0, rs1_busy}, 32'h1);
    check_eq("iss_wr7_busy_nb", {31'b0, nb_rs1_busy}, 32'h1);
    check_eq("iss_wr7_data", rs1_data, 32'h88);

    // Fill and sweep
    for (int k = 0; k < 32; k++) begin
      step();
      rd_wren_i = 1'b1; rd_addr_i = 5'(k); rd_data_i = 32'hFFFFFFFF;
    end
    step();
    clr_req_i = 1'b1; rs1_addr_i = 5'd9;
    #1;
    check_eq("clr_req_idle", {31'b0, clr_busy}, 32'h0);
    check_eq("fill9", rs1_data, 32'hFFFFFFFF);
    for (int c = 0; c < 32; c++) begin
      step();
      rs1_addr_i = 5'(c);
      rs2_addr_i = 5'(c - 1);
      if (c == 5) begin
        rd_wren_i = 1'b1; rd_addr_i = 5'd2; rd_data_i = 32'h55;
        iss_valid_i = 1'b1; iss_addr_i = 5'd9;
      end
      if (c == 10) clr_req_i = 1'b1;
      #1;
      check_eq($sformatf("sweep_busy_%0d", c), {31'b0, clr_busy}, 32'h1);
      check_eq($sformatf("sweep_rs1_%0d", c), rs1_data, (c == 0) ? 32'h0 : 32'hFFFFFFFF);
      check_eq($sformatf("sweep_rs1busy_%0d", c), {31'b0, rs1_busy}, 32'h0);
      if (c > 0) check_eq($sformatf("sweep_rs2_%0d", c), rs2_data, 32'h0);
    end
    step();
    rs1_addr_i = 5'd2; rs2_addr_i = 5'd9;
    #1;
    check_eq("sweep_done", {31'b0, clr_busy}, 32'h0);
    check_eq("sweep_done_nb", {31'b0, nb_clr_busy}, 32'h0);
    check_eq("clr_wr_dropped", rs1_data, 32'h0);
    check_eq("clr_iss_dropped", {31'b0, rs2_busy}, 32'h0);
    check_eq("entry9_cleared", rs2_data, 32'h0);
    rs1_addr_i = 5'd31;
    #1;
    check_eq("entry31_cleared", rs1_data, 32'h0);

    // Asynchronous reset while a write is pending
    step();
    rd_wren_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'hA5;
    iss_valid_i = 1'b1; iss_addr_i = 5'd4;
    step();
    rs1_addr_i = 5'd3; rs2_addr_i = 5'd4;
    #1;
    check_eq("pre_rst_data", rs1_data, 32'hA5);
    check_eq("pre_rst_busy", {31'b0, rs2_busy}, 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("arst_data", rs1_data, 32'h0);
    check_eq("arst_busy", {31'b0, rs2_busy}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Asynchronous reset mid-sweep
    step();
    rd_wren_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'hA5;
    step();
    clr_req_i = 1'b1;
    step();
    step();
    #1;
    check_eq("mid_clr_busy", {31'b0, clr_busy}, 32'h1);
    check_eq("mid_clr_data3", rs1_data, 32'hA5);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("arst_clr_busy", {31'b0, clr_busy}, 32'h0);
    check_eq("arst_clr_data3", rs1_data, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      check_eq($sformatf("no_resume_%0d", c), {31'b0, clr_busy}, 32'h0);
    end
    step();
    rd_wren_i = 1'b1; rd_addr_i = 5'd6; rd_data_i = 32'h600D; rs1_addr_i = 5'd6;
    #1;
    check_eq("post_rst_bypass", rs1_data, 32'h600D);
    step();
    #1;
    check_eq("post_rst_rd", rs1_data, 32'h600D);
    check_eq("post_rst_rd_nb", nb_rs1_data, 32'h600D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
